// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU memory responder: FSM state encoding,
// default address/data widths and the width of the wait-state counter.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// MAR/MDR memory bus between the CPU control unit (master) and the memory
// responder (slave).
//   Read, Write : request levels from the control unit
//   MARout      : 32-bit address from MAR
//   MDRdata     : write data from MDR
//   Mdatain     : read data returned to MDR
//   Done, Err   : one-cycle completion / illegal-request pulses
//   Busy        : responder is not idle
// -----------------------------------------------------------------------------
interface mem_responder_if #(
   parameter int DATA_W = cpu_mem_pkg::DATA_W_DEF
);
   logic              Read;
   logic              Write;
   logic [31:0]       MARout;
   logic [DATA_W-1:0] MDRdata;
   logic [DATA_W-1:0] Mdatain;
   logic              Done;
   logic              Busy;
   logic              Err;

   modport master (
      output Read, Write, MARout, MDRdata,
      input  Mdatain, Done, Busy, Err
   );

   modport slave (
      input  Read, Write, MARout, MDRdata,
      output Mdatain, Done, Busy, Err
   );
endinterface

// File: rtl/ram_sync.sv
// -----------------------------------------------------------------------------
// ram_sync
// Single-port RAM with synchronous write and synchronous (registered) read.
// The array itself is never reset; the read-data register is, so that it can
// serve directly as a registered output that holds the last value read.
//   clk    : rising-edge clock
//   rst_n  : async active-low reset of the read register only
//   we     : write enable (wdata -> mem[addr] at the edge)
//   re     : read enable (mem[addr] -> rdata at the edge)
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data, held while re is low
// -----------------------------------------------------------------------------
module ram_sync #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

   // Array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= {DATA_W{1'b0}};
      end else if (re) begin
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the MAR/MDR interface. Accepts one Read or Write
// request in IDLE, inserts WAIT_CYCLES wait states, performs the access on the
// internal RAM, then pulses Done (and Err for a Read+Write request) for one
// cycle.
//   clk : rising-edge clock
//   clr : asynchronous reset, active low
//   bus : slave side of mem_responder_if (Read, Write, MARout, MDRdata in;
//         Mdatain, Done, Busy, Err out, all registered)
// -----------------------------------------------------------------------------
module mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           clr,
   mem_responder_if.slave bus
);

   // Counter preload; unused when there are no wait states.
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] data_r, data_s;
   logic              is_write_r, is_write_s;
   logic              err_flag_r, err_flag_s;
   logic              done_r, busy_r, err_r;
   logic              ram_we_s, ram_re_s;
   logic [DATA_W-1:0] rdata_s;
   logic              unused_s;

   // Address bits above ADDR_W are deliberately ignored (aliasing).
   assign unused_s = ^bus.MARout[31:ADDR_W];

   // State, counter and request latches.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
         data_r     <= {DATA_W{1'b0}};
         is_write_r <= 1'b0;
         err_flag_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         addr_r     <= addr_s;
         data_r     <= data_s;
         is_write_r <= is_write_s;
         err_flag_r <= err_flag_s;
      end
   end

   // Next-state logic, request latching and RAM strobes.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      addr_s     = addr_r;
      data_s     = data_r;
      is_write_s = is_write_r;
      err_flag_s = err_flag_r;
      ram_we_s   = 1'b0;
      ram_re_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.Read && bus.Write) begin
               // Illegal request: nothing latched, no RAM access.
               err_flag_s = 1'b1;
               state_s    = ST_DONE;
            end else if (bus.Read ^ bus.Write) begin
               err_flag_s = 1'b0;
               addr_s     = bus.MARout[ADDR_W-1:0];
               data_s     = bus.MDRdata;
               is_write_s = bus.Write;
               if (WAIT_CYCLES == 0) begin
                  state_s = ST_ACCESS;
               end else begin
                  state_s = ST_WAIT;
                  cnt_s   = WAIT_LOAD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s = ST_ACCESS;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_ACCESS: begin
            // The RAM read register is the Mdatain register, so a read
            // lands at this same edge.
            ram_we_s = is_write_r;
            ram_re_s = !is_write_r;
            state_s  = ST_DONE;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         done_r <= 1'b0;
         busy_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         done_r <= (state_s == ST_DONE);
         busy_r <= (state_s != ST_IDLE);
         err_r  <= (state_s == ST_DONE) && err_flag_s;
      end
   end

   ram_sync #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (clr),
      .we    (ram_we_s),
      .re    (ram_re_s),
      .addr  (addr_r),
      .wdata (data_r),
      .rdata (rdata_s)
   );

   assign bus.Mdatain = rdata_s;
   assign bus.Done    = done_r;
   assign bus.Busy    = busy_r;
   assign bus.Err     = err_r;

endmodule
